// File: rtl/pc_recovery_ctrl.sv
// pc_recovery_ctrl: fault-recovery controller steering the PC hold/redirect inputs.
// Ports: clk; reset (async, active-low);
//   stall_req, branch_taken, branch_target: normal pipeline steering requests.
//   fault_detect: one-cycle fault pulse.
//   commit_valid, commit_pc: fault-free retirement and the next checkpoint address.
//   pc_hold, pc_redirect, redirect_addr: pc_control drive.
//   recovering, retry_cnt, fatal_fault: recovery status.
// Optional macro FAULT_TRAP_EN: escalation redirects to TRAP_VEC and resumes,
//   instead of halting until reset.
module pc_recovery_ctrl #(
  parameter int          MAX_RETRY    = 3,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        fault_detect,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  output logic        pc_hold,
  output logic        pc_redirect,
  output logic [31:0] redirect_addr,
  output logic        recovering,
  output logic [3:0]  retry_cnt,
  output logic        fatal_fault
);
  typedef enum logic [2:0] {RUN, FLUSH, REDIRECT, CONFIRM, ESCALATE} state_t;
  localparam logic [3:0] MAX_R   = 4'(MAX_RETRY);
  localparam logic [3:0] FLUSH_N = 4'(FLUSH_CYCLES);
  state_t      state, state_nx;
  logic [31:0] ckpt_pc;
  logic [3:0]  flush_cnt;
  logic        esc_pend;
  logic        enter_flush;
  logic        take_commit;
  assign enter_flush = (state == RUN || state == CONFIRM) && fault_detect;
  assign take_commit = (state == RUN || state == CONFIRM) && commit_valid && !fault_detect;
  assign recovering  = state != RUN;
  always_comb begin
    state_nx      = state;
    pc_hold       = stall_req & ~branch_taken;
    pc_redirect   = branch_taken;
    redirect_addr = branch_target;
    case (state)
      RUN:      state_nx = fault_detect ? FLUSH : RUN;
      FLUSH: begin
        pc_hold     = 1'b1;
        pc_redirect = 1'b0;
        if (flush_cnt <= 4'd1) state_nx = esc_pend ? ESCALATE : REDIRECT;
      end
      REDIRECT: begin
        pc_hold       = 1'b0;
        pc_redirect   = 1'b1;
        redirect_addr = ckpt_pc;
        state_nx      = CONFIRM;
      end
      CONFIRM:  state_nx = fault_detect ? FLUSH : commit_valid ? RUN : CONFIRM;
      ESCALATE: begin
`ifdef FAULT_TRAP_EN
        pc_hold       = 1'b0;
        pc_redirect   = 1'b1;
        redirect_addr = TRAP_VEC;
        state_nx      = RUN;
`else
        pc_hold       = 1'b1;
        pc_redirect   = 1'b0;
`endif
      end
      default:  state_nx = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      ckpt_pc     <= RESET_VEC;
      retry_cnt   <= 4'd0;
      flush_cnt   <= 4'd0;
      esc_pend    <= 1'b0;
      fatal_fault <= 1'b0;
    end else begin
      state <= state_nx;
      // The escalation decision is taken on FLUSH entry; the budget is only consumed when a retry remains.
      if (enter_flush) begin
        flush_cnt <= FLUSH_N;
        esc_pend  <= retry_cnt == MAX_R;
        if (retry_cnt != MAX_R) retry_cnt <= retry_cnt + 4'd1;
      end else if (state == FLUSH) begin
        flush_cnt <= flush_cnt - 4'd1;
      end
      if (take_commit) ckpt_pc <= commit_pc;
      if (take_commit && state == CONFIRM) retry_cnt <= 4'd0;
      if (state == FLUSH && state_nx == ESCALATE) fatal_fault <= 1'b1;
`ifdef FAULT_TRAP_EN
      if (state == ESCALATE) begin
        retry_cnt   <= 4'd0;
        fatal_fault <= 1'b0;
        ckpt_pc     <= TRAP_VEC;
      end
`endif
    end
  end
endmodule

// File: tb/tb_pc_recovery_ctrl.sv
// tb_pc_recovery_ctrl: randomized + directed check of pc_recovery_ctrl against an episode-level model.
module tb_pc_recovery_ctrl;
  localparam int MAX_RETRY = 3;
  localparam int FLUSH_CYCLES = 2;
  localparam logic [31:0] TRAP = 32'h100;
  localparam int M_RUN = 0, M_FLUSH = 1, M_REDIR = 2, M_CONF = 3, M_ESC = 4;
  logic clk = 0, reset = 0, stall_req = 0, branch_taken = 0, fault_detect = 0, commit_valid = 0;
  logic [31:0] branch_target = 0, commit_pc = 0, redirect_addr;
  logic pc_hold, pc_redirect, recovering, fatal_fault;
  logic [3:0] retry_cnt;
  logic rst_v = 0;
  int checks = 0, errors = 0;
  int m_phase, m_flush_left, m_retry;
  logic [31:0] m_ckpt;
  logic m_to_esc, m_fatal;
  pc_recovery_ctrl #(.MAX_RETRY(MAX_RETRY), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .reset(reset), .stall_req(stall_req), .branch_taken(branch_taken),
    .branch_target(branch_target), .fault_detect(fault_detect), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .pc_hold(pc_hold), .pc_redirect(pc_redirect),
    .redirect_addr(redirect_addr), .recovering(recovering), .retry_cnt(retry_cnt),
    .fatal_fault(fatal_fault));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    m_phase = M_RUN; m_flush_left = 0; m_retry = 0; m_ckpt = 32'h0; m_to_esc = 0; m_fatal = 0;
  endtask
  task automatic start_episode();
    m_phase = M_FLUSH;
    m_flush_left = FLUSH_CYCLES;
    m_to_esc = m_retry == MAX_RETRY;
    if (!m_to_esc) m_retry++;
  endtask
  task automatic drive(input logic st, input logic br, input logic [31:0] tgt,
                       input logic flt, input logic cv, input logic [31:0] cpc);
    logic e_hold, e_red;
    logic [31:0] e_addr;
    @(negedge clk);
    reset = rst_v; stall_req = st; branch_taken = br; branch_target = tgt;
    fault_detect = flt; commit_valid = cv; commit_pc = cpc;
    if (!rst_v) model_reset();
    #1;
    e_hold = st & ~br; e_red = br; e_addr = tgt;
    if (m_phase == M_FLUSH) begin e_hold = 1; e_red = 0; end
    if (m_phase == M_REDIR) begin e_hold = 0; e_red = 1; e_addr = m_ckpt; end
`ifdef FAULT_TRAP_EN
    if (m_phase == M_ESC) begin e_hold = 0; e_red = 1; e_addr = TRAP; end
`else
    if (m_phase == M_ESC) begin e_hold = 1; e_red = 0; end
`endif
    chk("pc_hold", pc_hold, e_hold);
    chk("pc_redirect", pc_redirect, e_red);
    if (e_red) chk("redirect_addr", redirect_addr, e_addr);
    chk("recovering", recovering, m_phase != M_RUN);
    chk("retry_cnt", retry_cnt, m_retry);
    chk("fatal_fault", fatal_fault, m_fatal);
  endtask
  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else case (m_phase)
      M_RUN: if (fault_detect) start_episode(); else if (commit_valid) m_ckpt = commit_pc;
      M_FLUSH: begin
        m_flush_left--;
        if (m_flush_left == 0) begin
          m_phase = m_to_esc ? M_ESC : M_REDIR;
          if (m_to_esc) m_fatal = 1;
        end
      end
      M_REDIR: m_phase = M_CONF;
      M_CONF:
        if (fault_detect) start_episode();
        else if (commit_valid) begin m_ckpt = commit_pc; m_retry = 0; m_phase = M_RUN; end
      default: begin
`ifdef FAULT_TRAP_EN
        m_phase = M_RUN; m_retry = 0; m_fatal = 0; m_ckpt = TRAP;
`endif
      end
    endcase
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    model_reset();
    rst_v = 0;
    idle();
    chk("reset_recovering", recovering, 0);
    chk("reset_retry", retry_cnt, 0);
    chk("reset_fatal", fatal_fault, 0);
    tick();
    rst_v = 1;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      chk("stall_hold", pc_hold, 1);
      chk("stall_noredir", pc_redirect, 0);
      chk("stall_rec", recovering, 0);
      tick();
    end
    drive(0, 0, 0, 0, 1, 32'h40); tick();
    drive(0, 0, 0, 1, 0, 0); tick();
    for (int i = 0; i < 2; i++) begin
      idle();
      chk("flush_hold", pc_hold, 1);
      chk("flush_retry", retry_cnt, 1);
      tick();
    end
    idle();
    chk("redir_pulse", pc_redirect, 1);
    chk("redir_addr", redirect_addr, 32'h40);
    chk("redir_hold", pc_hold, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'h44);
    chk("confirm_rec", recovering, 1);
    tick();
    idle();
    chk("commit_rec", recovering, 0);
    chk("commit_retry", retry_cnt, 0);
    tick();
    drive(0, 0, 0, 1, 1, 32'h80); tick();
    idle(); tick(); idle(); tick();
    idle();
    chk("fault_wins_addr", redirect_addr, 32'h44);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 1, 0, 0); tick();
      idle(); tick(); idle(); tick();
      idle();
      chk("retry_redir", pc_redirect, 1);
      tick();
    end
    chk("retry_max", retry_cnt, 3);
    drive(0, 0, 0, 1, 0, 0); tick();
    idle(); tick(); idle(); tick();
    drive(0, 1, 32'h999, 0, 0, 0);
    chk("esc_fatal", fatal_fault, 1);
    chk("esc_retry", retry_cnt, 3);
`ifdef FAULT_TRAP_EN
    chk("esc_trap_redir", pc_redirect, 1);
    chk("esc_trap_addr", redirect_addr, TRAP);
    tick();
    idle();
    chk("trap_run", recovering, 0);
    chk("trap_fatal_clr", fatal_fault, 0);
    tick();
`else
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h999, 0, 1, 32'h50);
      chk("esc_hold", pc_hold, 1);
      chk("esc_noredir", pc_redirect, 0);
      chk("esc_fatal_stays", fatal_fault, 1);
      tick();
    end
`endif
    rst_v = 0; idle(); tick(); rst_v = 1;
    drive(0, 0, 0, 0, 1, 32'h40); tick();
    drive(0, 0, 0, 1, 0, 0); tick();
    rst_v = 0;
    idle();
    chk("midflush_rst_hold", pc_hold, 0);
    chk("midflush_rst_rec", recovering, 0);
    chk("midflush_rst_retry", retry_cnt, 0);
    tick();
    rst_v = 1;
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("post_rst_noredir", pc_redirect, 0);
      tick();
    end
    for (int i = 0; i < 4000; i++) begin
      rst_v = ($urandom % 200) != 0;
      drive(($urandom % 4) == 0, ($urandom % 4) == 0, $urandom, ($urandom % 6) == 0,
            ($urandom % 3) == 0, $urandom);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
